// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile -- MIPS32 general-purpose register file
//
// Purpose:
//   Architectural register state for the core: 2**ADDR_W registers of DATA_W
//   bits. r0 is hardwired to zero. Writes are synchronous (one write-back
//   port driven from MEM/WB). The two read ports (rs/rt for decode) are
//   combinational.
//
// Optional feature (compile-time macro):
//   REGFILE_WB_BYPASS_EN  -- when defined, a read of the register being
//                            written in the same cycle returns in_wr_data
//                            (WB->ID forwarding). When undefined, the
//                            same-cycle read returns the old contents.
//
// Ports:
//   clk             in   1       rising-edge clock
//   rst             in   1       asynchronous, active-high reset; clears all
//                                registers and forces both read outputs to 0
//   in_wr_enable    in   1       write-back enable
//   in_wr_address   in   ADDR_W  write-back destination register
//   in_wr_data      in   DATA_W  write-back value
//   in_rd1_enable   in   1       read port 1 enable (rs)
//   in_rd1_address  in   ADDR_W  read port 1 address
//   out_rd1_data    out  DATA_W  read port 1 data
//   in_rd2_enable   in   1       read port 2 enable (rt)
//   in_rd2_address  in   ADDR_W  read port 2 address
//   out_rd2_data    out  DATA_W  read port 2 data
// -----------------------------------------------------------------------------
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_wr_enable,
  input  logic [ADDR_W-1:0] in_wr_address,
  input  logic [DATA_W-1:0] in_wr_data,
  input  logic              in_rd1_enable,
  input  logic [ADDR_W-1:0] in_rd1_address,
  output logic [DATA_W-1:0] out_rd1_data,
  input  logic              in_rd2_enable,
  input  logic [ADDR_W-1:0] in_rd2_address,
  output logic [DATA_W-1:0] out_rd2_data
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];

  logic w_wr_hit;
  logic w_rd1_byp;
  logic w_rd2_byp;

  // A write to r0 is dropped here, so r_regs[0] stays at its reset value of 0.
  assign w_wr_hit = in_wr_enable && (in_wr_address != '0);

`ifdef REGFILE_WB_BYPASS_EN
  assign w_rd1_byp = w_wr_hit && (in_wr_address == in_rd1_address);
  assign w_rd2_byp = w_wr_hit && (in_wr_address == in_rd2_address);
`else
  assign w_rd1_byp = 1'b0;
  assign w_rd2_byp = 1'b0;
`endif

  // Read-port selection in priority order: reset, disabled port, r0,
  // write-back bypass, stored contents.
  function automatic logic [DATA_W-1:0] rd_sel(
    input logic              f_rst,
    input logic              f_en,
    input logic [ADDR_W-1:0] f_addr,
    input logic              f_byp,
    input logic [DATA_W-1:0] f_wr_data,
    input logic [DATA_W-1:0] f_stored
  );
    if (f_rst || !f_en || (f_addr == '0)) begin
      return '0;
    end
    if (f_byp) begin
      return f_wr_data;
    end
    return f_stored;
  endfunction

  // Register array: asynchronous clear, synchronous write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_hit) begin
      r_regs[in_wr_address] <= in_wr_data;
    end
  end

  // Combinational read ports.
  always_comb begin
    out_rd1_data = rd_sel(rst, in_rd1_enable, in_rd1_address, w_rd1_byp,
                          in_wr_data, r_regs[in_rd1_address]);
    out_rd2_data = rd_sel(rst, in_rd2_enable, in_rd2_address, w_rd2_byp,
                          in_wr_data, r_regs[in_rd2_address]);
  end

endmodule

// File: tb/tb_regfile.sv
`timescale 1ns/10ps
module tb_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 2 ** ADDR_W;

  logic              clk;
  logic              rst;
  logic              in_wr_enable;
  logic [ADDR_W-1:0] in_wr_address;
  logic [DATA_W-1:0] in_wr_data;
  logic              in_rd1_enable;
  logic [ADDR_W-1:0] in_rd1_address;
  logic [DATA_W-1:0] out_rd1_data;
  logic              in_rd2_enable;
  logic [ADDR_W-1:0] in_rd2_address;
  logic [DATA_W-1:0] out_rd2_data;

  regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_wr_enable   (in_wr_enable),
    .in_wr_address  (in_wr_address),
    .in_wr_data     (in_wr_data),
    .in_rd1_enable  (in_rd1_enable),
    .in_rd1_address (in_rd1_address),
    .out_rd1_data   (out_rd1_data),
    .in_rd2_enable  (in_rd2_enable),
    .in_rd2_address (in_rd2_address),
    .out_rd2_data   (out_rd2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain array of architectural register values.
  logic [DATA_W-1:0] model [NREGS];
  int  n_checks;
  int  n_fail;
  bit  check_en;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] model_read(input logic en, input logic [ADDR_W-1:0] a);
    if (rst || !en || a == 0) return '0;
    if (BYPASS && in_wr_enable && in_wr_address == a) return in_wr_data;
    return model[a];
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state update: asynchronous clear, write on rising edge.
  always @(posedge rst) begin
    for (int i = 0; i < NREGS; i++) model[i] = '0;
  end

  always @(posedge clk) begin
    if (!rst && in_wr_enable && in_wr_address != 0) model[in_wr_address] = in_wr_data;
  end

  // Continuous compare, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_rd1", out_rd1_data, model_read(in_rd1_enable, in_rd1_address));
      check("cyc_rd2", out_rd2_data, model_read(in_rd2_enable, in_rd2_address));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_wr_enable   = 1'b0;
    in_wr_address  = '0;
    in_wr_data     = '0;
    in_rd1_enable  = 1'b1;
    in_rd1_address = '0;
    in_rd2_enable  = 1'b1;
    in_rd2_address = '0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    in_wr_enable  = 1'b1;
    in_wr_address = a;
    in_wr_data    = d;
    step();
    in_wr_enable  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    check_en = 1'b0;
    rst      = 1'b0;
    idle_inputs();
    for (int i = 0; i < NREGS; i++) model[i] = 'x;

    // Reset pulse before any clock edge; all registers read 0 on both ports.
    #1;
    rst = 1'b1;
    #0.05;
    rst = 1'b0;
    check_en = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      in_rd1_address = ADDR_W'(i);
      in_rd2_address = ADDR_W'(NREGS - 1 - i);
      #0.1;
      check("rst_clear_rd1", out_rd1_data, '0);
      check("rst_clear_rd2", out_rd2_data, '0);
    end

    // Outputs held at 0 while rst=1, even with writes and enables present.
    rst = 1'b1;
    in_wr_enable   = 1'b1;
    in_wr_address  = 5'd4;
    in_wr_data     = 32'hAAAA_5555;
    in_rd1_address = 5'd4;
    in_rd2_address = 5'd4;
    #0.1;
    check("rst_hold_rd1", out_rd1_data, '0);
    check("rst_hold_rd2", out_rd2_data, '0);
    step();
    step();
    idle_inputs();
    rst = 1'b0;
    in_rd1_address = 5'd4;
    #1;
    check("rst_no_write_r4", out_rd1_data, '0);

    // Basic write/read.
    do_write(5'd5, 32'hDEAD_BEEF);
    in_rd1_address = 5'd5;
    in_rd2_address = 5'd5;
    #2;
    check("basic_rd1", out_rd1_data, 32'hDEAD_BEEF);
    check("basic_rd2", out_rd2_data, 32'hDEAD_BEEF);
    step();

    // r0 protection.
    in_rd1_address = 5'd0;
    in_rd2_address = 5'd0;
    do_write(5'd0, 32'h1234_5678);
    #2;
    check("r0_rd1", out_rd1_data, '0);
    check("r0_rd2", out_rd2_data, '0);
    step();

    // Read enable.
    do_write(5'd7, 32'h0000_00FF);
    in_rd1_enable  = 1'b0;
    in_rd1_address = 5'd7;
    in_rd2_address = 5'd7;
    #2;
    check("rden_rd1_off", out_rd1_data, '0);
    check("rden_rd2_on", out_rd2_data, 32'h0000_00FF);
    step();
    in_rd1_enable = 1'b1;

    // Same-cycle hazard.
    do_write(5'd9, 32'h1);
    in_rd1_address = 5'd9;
    in_rd2_address = 5'd9;
    in_wr_enable   = 1'b1;
    in_wr_address  = 5'd9;
    in_wr_data     = 32'h2;
    #2;
    check("hazard_same_rd1", out_rd1_data, BYPASS ? 32'h2 : 32'h1);
    check("hazard_same_rd2", out_rd2_data, BYPASS ? 32'h2 : 32'h1);
    step();
    in_wr_enable = 1'b0;
    #2;
    check("hazard_next_rd1", out_rd1_data, 32'h2);
    check("hazard_next_rd2", out_rd2_data, 32'h2);
    step();

    // Randomized traffic, with read addresses often colliding with the write.
    for (int c = 0; c < 3000; c++) begin
      in_wr_enable   = ($urandom_range(0, 3) != 0);
      in_wr_address  = ADDR_W'($urandom_range(0, NREGS - 1));
      in_wr_data     = $urandom;
      in_rd1_enable  = ($urandom_range(0, 7) != 0);
      in_rd2_enable  = ($urandom_range(0, 7) != 0);
      in_rd1_address = ($urandom_range(0, 3) == 0) ? in_wr_address : ADDR_W'($urandom_range(0, NREGS - 1));
      in_rd2_address = ($urandom_range(0, 3) == 0) ? in_wr_address : ADDR_W'($urandom_range(0, NREGS - 1));
      step();
    end
    idle_inputs();

    // Reset mid-run: fill r1..r31, then assert rst between edges during a write.
    for (int i = 1; i < NREGS; i++) do_write(ADDR_W'(i), DATA_W'(i));
    in_rd1_address = 5'd3;
    in_rd2_address = 5'd31;
    #2;
    check("fill_r3", out_rd1_data, 32'd3);
    check("fill_r31", out_rd2_data, 32'd31);
    step();
    in_wr_enable  = 1'b1;
    in_wr_address = 5'd3;
    in_wr_data    = 32'hFFFF_FFFF;
    #2;
    rst = 1'b1;
    #0.1;
    check("midrst_rd1", out_rd1_data, '0);
    check("midrst_rd2", out_rd2_data, '0);
    step();
    rst = 1'b0;
    in_wr_enable = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      in_rd1_address = ADDR_W'(i);
      in_rd2_address = ADDR_W'(i);
      #0.2;
      check("midrst_after_rd1", out_rd1_data, '0);
      check("midrst_after_rd2", out_rd2_data, '0);
    end
    step();
    step();

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
